// File: rtl/wb_mem_ctrl_pkg.sv
// Shared definitions for the Wishbone memory controller: address map pages,
// slave indices, controller states and the address decoder.
package wb_mem_ctrl_pkg;

    // Upper address halfword selecting each region.
    localparam logic [15:0] MemPage = 16'hb000;  // ROM (addr[15]=0) and SRAM (addr[15]=1)
    localparam logic [15:0] IoPage  = 16'hc000;

    // Slave index doubles as the bit position in o_s_cyc/o_s_stb/i_s_ack/i_s_stall.
    typedef enum logic [1:0] {
        SlvRom  = 2'd0,
        SlvSram = 2'd1,
        SlvIo   = 2'd2,
        SlvNone = 2'd3
    } slave_e;

    typedef enum logic [1:0] {
        StIdle,
        StBusy,
        StErr,
        StAbort
    } state_e;

    function automatic slave_e decode_addr(input logic [31:0] addr);
        if (addr[31:16] == MemPage) begin
            return addr[15] ? SlvSram : SlvRom;
        end
        if (addr[31:16] == IoPage) begin
            return SlvIo;
        end
        return SlvNone;
    endfunction

endpackage

// File: rtl/wb_mem_ctrl_watchdog.sv
// Slave-response watchdog. Counts cycles while run is high and no kick arrives;
// expired pulses on the cycle the count would reach TIMEOUT, then the count restarts.
// Ports:
//   clk, reset  clock, asynchronous active-low reset
//   run         counting enabled (controller waiting on a slave)
//   kick        progress seen (an ack was passed), clears the count
//   expired     one-cycle timeout indication
module wb_mem_ctrl_watchdog #(
    parameter int unsigned TIMEOUT = 255
) (
    input  logic clk,
    input  logic reset,
    input  logic run,
    input  logic kick,
    output logic expired
);

    logic [15:0] count_q, count_d;

    // The count reaches TIMEOUT on the edge where expired is sampled high.
    assign expired = run & ~kick & (count_q == 16'(TIMEOUT - 1));

    always_comb begin
        count_d = count_q + 16'd1;
        if (!run || kick || expired) begin
            count_d = '0;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

endmodule

// File: rtl/wb_mem_ctrl.sv
// Pipelined Wishbone memory controller between the CPU master and ROM/SRAM/IO slaves.
// Requests are decoded and forwarded combinationally to one slave at a time; acks and
// read data come back only from the slave that owns the outstanding transfers.
// Unmapped accesses and slave timeouts raise a one-cycle registered bus error.
// Ports:
//   clk, reset                 clock, asynchronous active-low reset
//   i_wb_*                     master request (cyc, stb, we, byte addr, write data)
//   o_wb_data/ack/stall/err    master response
//   o_s_cyc/stb                per-slave {io,sram,rom} cycle and strobe
//   o_s_we/addr/data           shared slave request (addr is word address [13:2])
//   i_s_ack/stall/data         per-slave responses, data packed {io,sram,rom}
module wb_mem_ctrl
    import wb_mem_ctrl_pkg::*;
#(
    parameter int unsigned MAX_OUTSTANDING = 4,
    parameter int unsigned TIMEOUT         = 255
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        i_wb_cyc,
    input  logic        i_wb_stb,
    input  logic        i_wb_we,
    input  logic [31:0] i_wb_addr,
    input  logic [31:0] i_wb_data,
    output logic [31:0] o_wb_data,
    output logic        o_wb_ack,
    output logic        o_wb_stall,
    output logic        o_wb_err,
    output logic [2:0]  o_s_cyc,
    output logic [2:0]  o_s_stb,
    output logic        o_s_we,
    output logic [11:0] o_s_addr,
    output logic [31:0] o_s_data,
    input  logic [2:0]  i_s_ack,
    input  logic [2:0]  i_s_stall,
    input  logic [95:0] i_s_data
);

    state_e      state_q, state_d;
    slave_e      cur_slave_q, cur_slave_d;
    logic [3:0]  outstanding_q, outstanding_d;
    logic        err_q, err_d;

    slave_e      sel;
    logic        mapped, has_out, block, sel_stall, fwd, accept, ack_pass, expired;
    logic        cur_ack;
    logic [31:0] cur_data;
    logic [2:0]  cur_onehot;
    logic        unused_addr;

    assign unused_addr = ^{i_wb_addr[14], i_wb_addr[1:0]};

    assign sel     = decode_addr(i_wb_addr);
    assign mapped  = (sel != SlvNone);
    assign has_out = (outstanding_q != 4'd0);

    // New requests wait while recovering, while another slave still owes acks, or when full.
    assign block = ((state_q != StIdle) && (state_q != StBusy))
                 | (has_out && (sel != cur_slave_q))
                 | (outstanding_q == 4'(MAX_OUTSTANDING));

    always_comb begin
        case (sel)
            SlvRom:  sel_stall = i_s_stall[0];
            SlvSram: sel_stall = i_s_stall[1];
            SlvIo:   sel_stall = i_s_stall[2];
            default: sel_stall = 1'b0;
        endcase
    end

    assign o_wb_stall = i_wb_stb & (block | sel_stall);
    assign accept     = i_wb_cyc & i_wb_stb & ~o_wb_stall;
    assign fwd        = i_wb_cyc & i_wb_stb & ~block;

    assign o_s_stb = {fwd & (sel == SlvIo), fwd & (sel == SlvSram), fwd & (sel == SlvRom)};

    always_comb begin
        cur_onehot = 3'b000;
        cur_ack    = 1'b0;
        cur_data   = '0;
        case (cur_slave_q)
            SlvRom:  begin cur_onehot = 3'b001; cur_ack = i_s_ack[0]; cur_data = i_s_data[31:0];  end
            SlvSram: begin cur_onehot = 3'b010; cur_ack = i_s_ack[1]; cur_data = i_s_data[63:32]; end
            SlvIo:   begin cur_onehot = 3'b100; cur_ack = i_s_ack[2]; cur_data = i_s_data[95:64]; end
            default: ;
        endcase
    end

    assign o_s_cyc = (i_wb_cyc && state_q != StAbort) ?
                     ((has_out ? cur_onehot : 3'b000) | o_s_stb) : 3'b000;

    // Acks count only from the owning slave and only while something is outstanding.
    assign ack_pass  = has_out & cur_ack & (state_q != StAbort);
    assign o_wb_ack  = ack_pass;
    assign o_wb_data = has_out ? cur_data : '0;
    assign o_wb_err  = err_q;

    assign o_s_we   = i_wb_we;
    assign o_s_addr = i_wb_addr[13:2];
    assign o_s_data = i_wb_data;

    wb_mem_ctrl_watchdog #(
        .TIMEOUT (TIMEOUT)
    ) u_watchdog (
        .clk     (clk),
        .reset   (reset),
        .run     ((state_q == StBusy) && i_wb_cyc),
        .kick    (ack_pass),
        .expired (expired)
    );

    always_comb begin
        state_d       = state_q;
        cur_slave_d   = cur_slave_q;
        outstanding_d = outstanding_q;
        err_d         = 1'b0;

        if (accept && mapped) begin
            cur_slave_d = sel;
        end

        case ({accept && mapped, ack_pass})
            2'b10:   outstanding_d = outstanding_q + 4'd1;
            2'b01:   outstanding_d = outstanding_q - 4'd1;
            default: outstanding_d = outstanding_q;
        endcase

        unique case (state_q)
            StIdle: begin
                if (accept && mapped) begin
                    state_d = StBusy;
                end else if (accept) begin
                    // Unmapped request is swallowed: no strobe, no ack, error next cycle.
                    state_d = StErr;
                    err_d   = 1'b1;
                end
            end
            StBusy: begin
                if (!i_wb_cyc) begin
                    // Master abandoned the cycle; drop owed acks silently.
                    outstanding_d = '0;
                    state_d       = StAbort;
                end else if (expired) begin
                    outstanding_d = '0;
                    err_d         = 1'b1;
                    state_d       = StAbort;
                end else if (outstanding_d == 4'd0) begin
                    state_d = StIdle;
                end
            end
            StErr:   state_d = StIdle;
            StAbort: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q       <= StIdle;
            cur_slave_q   <= SlvRom;
            outstanding_q <= '0;
            err_q         <= 1'b0;
        end else begin
            state_q       <= state_d;
            cur_slave_q   <= cur_slave_d;
            outstanding_q <= outstanding_d;
            err_q         <= err_d;
        end
    end

endmodule

// File: tb/tb_wb_mem_ctrl.sv
module tb_wb_mem_ctrl;

    localparam int MAXO = 4;
    localparam int TMO  = 8;

    logic        clk = 1'b0;
    logic        reset;
    logic        i_wb_cyc, i_wb_stb, i_wb_we;
    logic [31:0] i_wb_addr, i_wb_data;
    logic [31:0] o_wb_data;
    logic        o_wb_ack, o_wb_stall, o_wb_err;
    logic [2:0]  o_s_cyc, o_s_stb;
    logic        o_s_we;
    logic [11:0] o_s_addr;
    logic [31:0] o_s_data;
    logic [2:0]  i_s_ack, i_s_stall;
    logic [95:0] i_s_data;

    always #5 clk = ~clk;

    wb_mem_ctrl #(
        .MAX_OUTSTANDING (MAXO),
        .TIMEOUT         (TMO)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .i_wb_cyc   (i_wb_cyc),
        .i_wb_stb   (i_wb_stb),
        .i_wb_we    (i_wb_we),
        .i_wb_addr  (i_wb_addr),
        .i_wb_data  (i_wb_data),
        .o_wb_data  (o_wb_data),
        .o_wb_ack   (o_wb_ack),
        .o_wb_stall (o_wb_stall),
        .o_wb_err   (o_wb_err),
        .o_s_cyc    (o_s_cyc),
        .o_s_stb    (o_s_stb),
        .o_s_we     (o_s_we),
        .o_s_addr   (o_s_addr),
        .o_s_data   (o_s_data),
        .i_s_ack    (i_s_ack),
        .i_s_stall  (i_s_stall),
        .i_s_data   (i_s_data)
    );

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h @%0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_in();
        i_wb_stb  = 1'b0;
        i_wb_we   = 1'b0;
        i_wb_addr = '0;
        i_wb_data = '0;
        i_s_ack   = '0;
        i_s_stall = '0;
        i_s_data  = '0;
    endtask

    // Combinational decode vectors, applied from IDLE without clocking.
    typedef struct {
        logic [31:0] addr;
        logic [2:0]  s_stall;
        logic [2:0]  exp_stb;
        logic        exp_stall;
    } vec_t;
    vec_t vecs[8];

    // Reference model: in-order list of accepted transfers still owed an ack.
    typedef struct {
        int          slv;
        logic [31:0] data;
        int          due;
    } txn_t;
    txn_t q[$];
    logic err_now;

    task automatic rand_cycle(input int now, input bit allow_req);
        int          r, sel, st, due;
        logic [31:0] addr;
        logic        ack_head, mapped, blocked, exp_stall;
        logic [2:0]  exp_stb, exp_cyc;
        r   = $urandom_range(0, 9);
        sel = (r < 3) ? 0 : (r < 6) ? 1 : (r < 9) ? 2 : 3;
        case (sel)
            0:       addr = 32'hb000_0000 | ($urandom & 32'h0000_7ffc);
            1:       addr = 32'hb000_8000 | ($urandom & 32'h0000_7ffc);
            2:       addr = 32'hc000_0000 | ($urandom & 32'h0000_fffc);
            default: addr = 32'h1000_0000 + ($urandom & 32'h0fff_fffc);
        endcase
        i_wb_stb  = allow_req && ($urandom_range(0, 9) < 6);
        i_wb_addr = addr;
        i_wb_we   = 1'($urandom);
        i_wb_data = $urandom;
        i_s_stall = {$urandom_range(0, 4) == 0, $urandom_range(0, 4) == 0,
                     $urandom_range(0, 4) == 0};
        i_s_data  = {$urandom, $urandom, $urandom};
        i_s_ack   = '0;
        ack_head  = (q.size() > 0) && (q[0].due <= now);
        if (ack_head) begin
            i_s_ack[q[0].slv]            = 1'b1;
            i_s_data[q[0].slv*32 +: 32]  = q[0].data;
        end else if ($urandom_range(0, 7) == 0) begin
            st = $urandom_range(0, 2);
            if (q.size() == 0 || st != q[0].slv) i_s_ack[st] = 1'b1;
        end
        #1;
        mapped    = (sel != 3);
        blocked   = err_now || (q.size() > 0 && sel != q[0].slv) || (q.size() == MAXO);
        exp_stall = i_wb_stb && (blocked || (mapped && i_s_stall[sel]));
        exp_stb   = (i_wb_stb && !blocked && mapped) ? 3'(1 << sel) : 3'b000;
        exp_cyc   = exp_stb | ((q.size() > 0) ? 3'(1 << q[0].slv) : 3'b000);
        chk("rnd_stall", 32'(o_wb_stall), 32'(exp_stall));
        chk("rnd_stb", 32'(o_s_stb), 32'(exp_stb));
        chk("rnd_cyc", 32'(o_s_cyc), 32'(exp_cyc));
        chk("rnd_ack", 32'(o_wb_ack), 32'(ack_head));
        chk("rnd_err", 32'(o_wb_err), 32'(err_now));
        if (ack_head) chk("rnd_data", o_wb_data, q[0].data);
        if (exp_stb != 0) chk("rnd_addr", 32'(o_s_addr), 32'(addr[13:2]));
        if (ack_head) void'(q.pop_front());
        err_now = 1'b0;
        if (i_wb_stb && !exp_stall) begin
            if (mapped) begin
                due = now + 1 + $urandom_range(0, 3);
                if (q.size() > 0 && q[$].due + 1 > due) due = q[$].due + 1;
                q.push_back('{sel, $urandom, due});
            end else begin
                err_now = 1'b1;
            end
        end
    endtask

    initial begin
        vecs[0] = '{32'hb000_0010, 3'b000, 3'b001, 1'b0};
        vecs[1] = '{32'hb000_7ffc, 3'b000, 3'b001, 1'b0};
        vecs[2] = '{32'hb000_8000, 3'b000, 3'b010, 1'b0};
        vecs[3] = '{32'hb000_fffc, 3'b000, 3'b010, 1'b0};
        vecs[4] = '{32'hc000_0004, 3'b000, 3'b100, 1'b0};
        vecs[5] = '{32'hc000_fff0, 3'b100, 3'b100, 1'b1};
        vecs[6] = '{32'hb001_0000, 3'b000, 3'b000, 1'b0};
        vecs[7] = '{32'ha000_0000, 3'b111, 3'b000, 1'b0};

        clear_in();
        i_wb_cyc = 1'b0;
        err_now  = 1'b0;
        reset    = 1'b1;
        #2 reset = 1'b0;
        #1;
        chk("rst_ack", 32'(o_wb_ack), 0);
        chk("rst_err", 32'(o_wb_err), 0);
        chk("rst_stall", 32'(o_wb_stall), 0);
        chk("rst_cyc", 32'(o_s_cyc), 0);
        chk("rst_stb", 32'(o_s_stb), 0);
        tick();
        reset    = 1'b1;
        i_wb_cyc = 1'b1;
        tick();

        // Decode table
        for (int i = 0; i < 8; i++) begin
            i_wb_addr = vecs[i].addr;
            i_s_stall = vecs[i].s_stall;
            i_wb_stb  = 1'b1;
            #1;
            chk($sformatf("vec%0d_stb", i), 32'(o_s_stb), 32'(vecs[i].exp_stb));
            chk($sformatf("vec%0d_cyc", i), 32'(o_s_cyc), 32'(vecs[i].exp_stb));
            chk($sformatf("vec%0d_stall", i), 32'(o_wb_stall), 32'(vecs[i].exp_stall));
            chk($sformatf("vec%0d_addr", i), 32'(o_s_addr), 32'(vecs[i].addr[13:2]));
            i_wb_stb  = 1'b0;
            i_s_stall = '0;
            #1;
        end

        // Single ROM read
        i_wb_stb = 1'b1; i_wb_addr = 32'hb000_0010; #1;
        chk("t1_stb", 32'(o_s_stb), 32'b001);
        chk("t1_addr", 32'(o_s_addr), 32'h004);
        tick();
        i_wb_stb = 1'b0; i_s_ack = 3'b001; i_s_data = {64'h0, 32'hdeadbeef}; #1;
        chk("t1_ack", 32'(o_wb_ack), 1);
        chk("t1_data", o_wb_data, 32'hdeadbeef);
        tick();
        clear_in(); #1;
        chk("t1_ack_gone", 32'(o_wb_ack), 0);
        chk("t1_drained", 32'(o_s_cyc), 0);

        // Four pipelined SRAM writes fill the window; the fifth waits for an ack
        i_wb_we = 1'b1;
        for (int i = 0; i < 4; i++) begin
            i_wb_stb = 1'b1; i_wb_addr = 32'hb000_8000 + 32'(4 * i); #1;
            chk($sformatf("t2_acc%0d_stall", i), 32'(o_wb_stall), 0);
            chk($sformatf("t2_acc%0d_stb", i), 32'(o_s_stb), 32'b010);
            tick();
        end
        i_wb_addr = 32'hb000_8010; #1;
        chk("t2_full_stall", 32'(o_wb_stall), 1);
        chk("t2_full_stb", 32'(o_s_stb), 0);
        tick();
        chk("t2_full_stall2", 32'(o_wb_stall), 1);
        i_s_ack = 3'b010; #1;
        chk("t2_ack1", 32'(o_wb_ack), 1);
        chk("t2_stall_during_ack", 32'(o_wb_stall), 1);
        tick();
        i_s_ack = 3'b000; #1;
        chk("t2_fifth_stall", 32'(o_wb_stall), 0);
        chk("t2_fifth_stb", 32'(o_s_stb), 32'b010);
        tick();
        i_wb_stb = 1'b0;
        for (int i = 0; i < 4; i++) begin
            i_s_ack = 3'b010; #1;
            chk($sformatf("t2_drain%0d", i), 32'(o_wb_ack), 1);
            tick();
        end
        clear_in(); #1;
        chk("t2_idle", 32'(o_s_cyc), 0);

        // ROM read then IO read: IO waits until ROM has acked
        i_wb_stb = 1'b1; i_wb_addr = 32'hb000_0000; #1;
        tick();
        i_wb_addr = 32'hc000_0004; #1;
        chk("t3_switch_stall", 32'(o_wb_stall), 1);
        chk("t3_switch_stb", 32'(o_s_stb), 0);
        i_s_ack = 3'b001; i_s_data = {64'h0, 32'h0000_1111}; #1;
        chk("t3_rom_ack", 32'(o_wb_ack), 1);
        chk("t3_stall_on_ack", 32'(o_wb_stall), 1);
        tick();
        i_s_ack = 3'b000; #1;
        chk("t3_io_stall", 32'(o_wb_stall), 0);
        chk("t3_io_stb", 32'(o_s_stb), 32'b100);
        chk("t3_io_cyc", 32'(o_s_cyc), 32'b100);
        tick();
        i_wb_stb = 1'b0; i_s_ack = 3'b100; i_s_data = {32'h1234_5678, 64'h0}; #1;
        chk("t3_io_ack", 32'(o_wb_ack), 1);
        chk("t3_io_data", o_wb_data, 32'h1234_5678);
        tick();
        clear_in();

        // Unmapped access: swallowed, error pulse, next request normal
        i_wb_stb = 1'b1; i_wb_addr = 32'h8000_0000; #1;
        chk("t4_stb", 32'(o_s_stb), 0);
        chk("t4_stall", 32'(o_wb_stall), 0);
        tick();
        i_wb_stb = 1'b0; #1;
        chk("t4_err", 32'(o_wb_err), 1);
        chk("t4_noack", 32'(o_wb_ack), 0);
        tick();
        chk("t4_err_off", 32'(o_wb_err), 0);
        i_wb_stb = 1'b1; i_wb_addr = 32'hb000_0004; #1;
        chk("t4_next_stb", 32'(o_s_stb), 32'b001);
        tick();
        i_wb_stb = 1'b0; i_s_ack = 3'b001; i_s_data = {64'h0, 32'hcafe_f00d}; #1;
        chk("t4_next_data", o_wb_data, 32'hcafe_f00d);
        tick();
        clear_in();

        // SRAM never acks: timeout after TMO cycles, then a one-cycle abort
        i_wb_stb = 1'b1; i_wb_addr = 32'hb000_8000; #1;
        tick();
        i_wb_stb = 1'b0;
        for (int k = 1; k < TMO; k++) begin
            tick();
            chk($sformatf("t5_noerr%0d", k), 32'(o_wb_err), 0);
            if (k == 1) chk("t5_busy_cyc", 32'(o_s_cyc), 32'b010);
        end
        tick();
        chk("t5_err", 32'(o_wb_err), 1);
        chk("t5_abort_cyc", 32'(o_s_cyc), 0);
        i_wb_stb = 1'b1; i_wb_addr = 32'hb000_0000; i_s_ack = 3'b010; #1;
        chk("t5_abort_stall", 32'(o_wb_stall), 1);
        chk("t5_abort_stb", 32'(o_s_stb), 0);
        chk("t5_abort_ack", 32'(o_wb_ack), 0);
        i_wb_stb = 1'b0;
        tick();
        chk("t5_err_off", 32'(o_wb_err), 0);
        chk("t5_stray_ack", 32'(o_wb_ack), 0);
        clear_in();
        tick();

        // Asynchronous reset with two IO reads outstanding
        i_wb_stb = 1'b1; i_wb_addr = 32'hc000_0000; #1;
        tick();
        i_wb_addr = 32'hc000_0004; #1;
        tick();
        i_wb_stb = 1'b0; #1;
        chk("t6_busy_cyc", 32'(o_s_cyc), 32'b100);
        reset = 1'b0; #1;
        i_s_ack = 3'b100; i_s_data = {32'h5555_aaaa, 64'h0}; #1;
        chk("t6_cyc", 32'(o_s_cyc), 0);
        chk("t6_ack", 32'(o_wb_ack), 0);
        chk("t6_data", o_wb_data, 0);
        chk("t6_err", 32'(o_wb_err), 0);
        reset = 1'b1;
        tick();
        chk("t6_late_ack", 32'(o_wb_ack), 0);
        chk("t6_late_cyc", 32'(o_s_cyc), 0);
        clear_in();
        tick();

        // Randomized traffic against the transfer-list model
        q.delete();
        err_now = 1'b0;
        for (int c = 0; c < 3000; c++) begin
            rand_cycle(c, c < 2980);
            @(posedge clk);
            #1;
        end
        clear_in(); #1;
        chk("rnd_final_idle", 32'(o_s_cyc), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
